logic_ops: RTL and testbench
============================

# logic_ops

Registered 20-bit bitwise logic unit for the ALU's logic class of operations. Computes NOT, AND, OR (and optionally XOR) on two operands and produces the result with a zero flag. The result is captured in an output register one cycle after a valid request. It sits beside the arithmetic class inside the ALU and feeds the result/flag mux.

## Interface
Parameters:
- WIDTH, default 20: operand and result width in bits.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  Request strobe; operands and op are sampled when high.
- op  input  2  Operation select: 00 NOT, 01 AND, 10 OR, 11 XOR (see Configuration).
- a  input  WIDTH  First operand.
- b  input  WIDTH  Second operand; ignored for NOT.
- c  output  WIDTH  Registered result.
- zero  output  1  Registered flag; high when c is all zeros.
- err  output  1  Registered flag; high when the captured op was unsupported.
- out_valid  output  1  High for exactly one cycle per accepted request.

## Operation
- Four combinational sub-units, each WIDTH bits:
  - NOT: ~a.
  - AND: a & b.
  - OR: a | b.
  - XOR: a ^ b.
- Each sub-unit also produces its own zero = (result == 0).
- op selects one sub-unit output. The selection and its zero flag are the next-state values of c and zero.
- Accepting a request (in_valid = 1 at a rising edge):
  - c, zero and err load from the selected sub-unit.
  - out_valid <= 1.
- No request (in_valid = 0 at a rising edge):
  - c, zero and err hold their last values.
  - out_valid <= 0.
- The unit is pure bitwise logic: no carry, overflow or sign handling.
- zero always equals (c == 0) at every cycle, including after reset.
- err is 0 for every supported op.
- No backpressure: a request may be issued every cycle, and each one yields one out_valid pulse.

## Timing
- Latency is 1 cycle: a request sampled at edge N gives c/zero/err/out_valid valid after edge N.
- Throughput is one request per cycle.
- Reset values (applied immediately, without waiting for clk): c = 0, zero = 1, err = 0, out_valid = 0.
- Reset during back-to-back requests:
  - Any in-flight result is discarded and out_valid drops immediately.
  - The first edge after rst deasserts samples normally.
- Changes to a, b or op while in_valid = 0 have no effect on the outputs.

## Configuration
- LOGIC_OPS_XOR_EN defined:
  - The XOR sub-unit is compiled in.
  - op = 11 yields c = a ^ b with the matching zero, and err = 0.
- LOGIC_OPS_XOR_EN undefined:
  - The XOR sub-unit is omitted.
  - op = 11 still produces out_valid = 1, with c = 0, zero = 1, err = 1.
- Ops 00, 01 and 10 are identical in both builds.

## Test plan
- NOT:
  - op = 00, a = 20'h00000, b = 20'h12345, in_valid = 1 -> next cycle c = FFFFF, zero = 0, err = 0, out_valid = 1.
  - a = 20'hFFFFF -> c = 00000, zero = 1.
- AND: op = 01, a = F0F0F, b = 0F0F0 -> c = 00000, zero = 1. Then a = FFFFF, b = 0A5A5 -> c = 0A5A5, zero = 0.
- OR: op = 10, a = F0F0F, b = 0F0F0 -> c = FFFFF, zero = 0. Then a = 0, b = 0 -> c = 00000, zero = 1.
- XOR / op 11:
  - a = AAAAA, b = FFFFF.
  - With LOGIC_OPS_XOR_EN -> c = 55555, zero = 0, err = 0.
  - Without it -> c = 00000, zero = 1, err = 1.
- Hold and back-to-back:
  - Three consecutive requests (AND, OR, NOT) -> three consecutive out_valid pulses with the correct results.
  - Then in_valid = 0 while a and b toggle -> c and zero hold, out_valid = 0.
- Reset:
  - Assert rst asynchronously mid-stream, between edges -> c = 0, zero = 1, err = 0, out_valid = 0 immediately.
  - After release, OR of 00001 | 00010 -> c = 00011 one cycle later.

Source files
------------

// File: rtl/logic_ops.sv
// ---------------------------------------------------------------------------
// LogicOps : registered bitwise logic unit for the ALU logic class.
//
// Computes NOT, AND, OR and (optionally) XOR on two WIDTH-bit operands and
// registers the selected result together with a zero flag and an error flag
// one cycle after a valid request. Outputs hold between requests.
//
// Optional feature macro: LOGIC_OPS_XOR_EN
//   defined   -> op 11 computes a ^ b
//   undefined -> op 11 is unsupported: c = 0, zero = 1, err = 1
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      request strobe, operands/op sampled when high
//   op         in   2      00 NOT, 01 AND, 10 OR, 11 XOR
//   a          in   WIDTH  first operand
//   b          in   WIDTH  second operand (ignored for NOT)
//   c          out  WIDTH  registered result
//   zero       out  1      registered flag, high when c is all zeros
//   err        out  1      registered flag, high when captured op unsupported
//   out_valid  out  1      one-cycle pulse per accepted request
// ---------------------------------------------------------------------------
module logic_ops #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             err,
    output logic             out_valid
);

    // Operation encodings shared by the select logic.
    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } opSel_t;

    logic [WIDTH-1:0] w_notRes;
    logic [WIDTH-1:0] w_andRes;
    logic [WIDTH-1:0] w_orRes;
    logic             w_notZero;
    logic             w_andZero;
    logic             w_orZero;

    logic [WIDTH-1:0] w_selRes;
    logic             w_selZero;
    logic             w_selErr;

    logic [WIDTH-1:0] r_c;
    logic             r_zero;
    logic             r_err;
    logic             r_outValid;

    // Each sub-unit produces its own result and its own zero flag.
    assign w_notRes  = ~a;
    assign w_andRes  = a & b;
    assign w_orRes   = a | b;
    assign w_notZero = (w_notRes == '0);
    assign w_andZero = (w_andRes == '0);
    assign w_orZero  = (w_orRes  == '0);

`ifdef LOGIC_OPS_XOR_EN
    logic [WIDTH-1:0] w_xorRes;
    logic             w_xorZero;

    assign w_xorRes  = a ^ b;
    assign w_xorZero = (w_xorRes == '0);
`endif

    // Pick the sub-unit named by op. When XOR is not built, op 11 yields a
    // cleared result with zero set so the zero == (c == 0) invariant holds.
    always_comb begin
        w_selRes  = '0;
        w_selZero = 1'b1;
        w_selErr  = 1'b0;
        case (opSel_t'(op))
            OP_NOT: begin
                w_selRes  = w_notRes;
                w_selZero = w_notZero;
            end
            OP_AND: begin
                w_selRes  = w_andRes;
                w_selZero = w_andZero;
            end
            OP_OR: begin
                w_selRes  = w_orRes;
                w_selZero = w_orZero;
            end
            OP_XOR: begin
`ifdef LOGIC_OPS_XOR_EN
                w_selRes  = w_xorRes;
                w_selZero = w_xorZero;
`else
                w_selRes  = '0;
                w_selZero = 1'b1;
                w_selErr  = 1'b1;
`endif
            end
            default: begin
                w_selRes  = '0;
                w_selZero = 1'b1;
                w_selErr  = 1'b1;
            end
        endcase
    end

    // Output register: loads on a request, otherwise holds. out_valid is a
    // single-cycle pulse per accepted request. Reset clears everything
    // immediately and leaves zero high to match the cleared result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c        <= '0;
            r_zero     <= 1'b1;
            r_err      <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_c    <= w_selRes;
                r_zero <= w_selZero;
                r_err  <= w_selErr;
            end
        end
    end

    assign c         = r_c;
    assign zero      = r_zero;
    assign err       = r_err;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_logic_ops.sv
// ---------------------------------------------------------------------------
// tb_logic_ops : self-checking bench for logic_ops (WIDTH = 20).
// Directed vector table, hand-written back-to-back / hold / reset sequences,
// then randomized requests against a bit-level truth-table model.
// ---------------------------------------------------------------------------
module tb_logic_ops;

    localparam int W = 20;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         zero;
    logic         err;
    logic         outValid;

    int total;
    int bad;

    logic [W-1:0] modelC;
    logic         modelZero;
    logic         modelErr;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expC;
        logic         expZero;
        logic         expErr;
    } vec_t;

    vec_t vecs[7];

    logic_ops #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .zero      (zero),
        .err       (err),
        .out_valid (outValid)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: evaluates each bit from the operation's truth table
    // using integer arithmetic, then derives zero from a population count.
    task automatic refModel(input logic [1:0] mOp, input logic [W-1:0] mA,
                            input logic [W-1:0] mB, output logic [W-1:0] rC,
                            output logic rZero, output logic rErr);
        int ones;
        int x;
        int y;
        int r;
        ones = 0;
        rErr = 1'b0;
        rC   = '0;
        for (int i = 0; i < W; i++) begin
            x = int'(mA[i]);
            y = int'(mB[i]);
            case (mOp)
                2'd0:    r = 1 - x;
                2'd1:    r = x * y;
                2'd2:    r = x + y - x * y;
`ifdef LOGIC_OPS_XOR_EN
                default: r = (x + y) % 2;
`else
                default: begin r = 0; rErr = 1'b1; end
`endif
            endcase
            rC[i] = (r != 0);
            ones  = ones + r;
        end
        rZero = (ones == 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] sOp,
                                 input logic [W-1:0] sA, input logic [W-1:0] sB);
        @(negedge clk);
        inValid = v;
        op      = sOp;
        a       = sA;
        b       = sB;
    endtask

    task automatic sampleAfterEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string name, input logic [W-1:0] eC,
                            input logic eZero, input logic eErr, input logic eValid);
        checkOutput({name, ".c"},         32'(c),        32'(eC));
        checkOutput({name, ".zero"},      32'(zero),     32'(eZero));
        checkOutput({name, ".err"},       32'(err),      32'(eErr));
        checkOutput({name, ".out_valid"}, 32'(outValid), 32'(eValid));
    endtask

    initial begin
        logic [W-1:0] rC;
        logic         rZ;
        logic         rE;
        logic         v;
        logic [1:0]   rOp;
        logic [W-1:0] rA;
        logic [W-1:0] rB;

        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        inValid = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;

        // Directed vectors with hand-computed results.
        vecs[0] = '{2'b00, 20'h00000, 20'h12345, 20'hFFFFF, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 20'hFFFFF, 20'h12345, 20'h00000, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 20'hF0F0F, 20'h0F0F0, 20'h00000, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 20'hFFFFF, 20'h0A5A5, 20'h0A5A5, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 20'hF0F0F, 20'h0F0F0, 20'hFFFFF, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 20'h00000, 20'h00000, 20'h00000, 1'b1, 1'b0};
`ifdef LOGIC_OPS_XOR_EN
        vecs[6] = '{2'b11, 20'hAAAAA, 20'hFFFFF, 20'h55555, 1'b0, 1'b0};
`else
        vecs[6] = '{2'b11, 20'hAAAAA, 20'hFFFFF, 20'h00000, 1'b1, 1'b1};
`endif

        // Reset applies without a clock edge.
        #2 rst = 1'b1;
        #1;
        checkAll("reset", 20'h00000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven requests, issued back to back.
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            sampleAfterEdge();
            checkAll($sformatf("vec%0d", i), vecs[i].expC, vecs[i].expZero,
                     vecs[i].expErr, 1'b1);
        end

        // Three consecutive requests: AND, OR, NOT.
        applyStimulus(1'b1, 2'b01, 20'h3C3C3, 20'h0FF00);
        sampleAfterEdge();
        checkAll("b2b_and", 20'h0C300, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b10, 20'h10001, 20'h01000);
        sampleAfterEdge();
        checkAll("b2b_or", 20'h11001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 20'h0F0F0, 20'h00000);
        sampleAfterEdge();
        checkAll("b2b_not", 20'hF0F0F, 1'b0, 1'b0, 1'b1);

        // Idle cycles with toggling operands: outputs hold.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'(i), 20'(32'h5A5A5 ^ (i * 32'h11111)), 20'(i));
            sampleAfterEdge();
            checkAll($sformatf("hold%0d", i), 20'hF0F0F, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges during a request stream.
        applyStimulus(1'b1, 2'b01, 20'hFFFFF, 20'hFFFFF);
        sampleAfterEdge();
        checkAll("pre_rst", 20'hFFFFF, 1'b0, 1'b0, 1'b1);
        #2;
        rst     = 1'b1;
        inValid = 1'b0;
        #1;
        checkAll("mid_rst", 20'h00000, 1'b1, 1'b0, 1'b0);

        // Release and request on the same negedge: first edge samples.
        @(negedge clk);
        rst     = 1'b0;
        inValid = 1'b1;
        op      = 2'b10;
        a       = 20'h00001;
        b       = 20'h00010;
        sampleAfterEdge();
        checkAll("post_rst_or", 20'h00011, 1'b0, 1'b0, 1'b1);

        modelC    = 20'h00011;
        modelZero = 1'b0;
        modelErr  = 1'b0;

        // Randomized requests with random gaps against the model.
        for (int i = 0; i < 300; i++) begin
            v   = (($urandom % 4) != 0);
            rOp = 2'($urandom % 4);
            rA  = 20'($urandom);
            rB  = 20'($urandom);
            if (($urandom % 8) == 0) rA = '0;
            if (($urandom % 8) == 0) rB = 20'hFFFFF;
            applyStimulus(v, rOp, rA, rB);
            sampleAfterEdge();
            if (v) begin
                refModel(rOp, rA, rB, rC, rZ, rE);
                modelC    = rC;
                modelZero = rZ;
                modelErr  = rE;
            end
            checkAll($sformatf("rand%0d", i), modelC, modelZero, modelErr, v);
        end

        applyStimulus(1'b0, 2'b00, '0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
